rr_burst_xfer: RTL
==================

Name: rr_burst_xfer

Overview:
- Downstream consumer of the round-robin req/grant arbiter's registered one-hot grant vector.
- Latches the granted client, moves that client's burst (1..2^LEN_W beats) through a single registered output stage with valid/ready, then signals completion so the client drops req.
- Waits for the arbiter to retire the grant before accepting the next one, so a lingering grant cannot restart a burst.

Parameters:
- NUM_CLIENTS, 4, number of requesters; must match the arbiter; >=2.
- DATA_W, 32, payload width per beat.
- LEN_W, 4, width of the per-client burst length field, encoded as beats-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- grant  input  NUM_CLIENTS  one-hot grant from the arbiter.
- cli_len  input  NUM_CLIENTS*LEN_W  per-client burst length minus 1; slice i belongs to client i.
- cli_data  input  NUM_CLIENTS*DATA_W  per-client beat data.
- cli_valid  input  NUM_CLIENTS  per-client beat valid.
- cli_ready  output  NUM_CLIENTS  per-client beat accept; combinational, at most one bit high.
- cli_done  output  NUM_CLIENTS  one-cycle pulse to the owner after its last beat is accepted.
- out_valid  output  1  output beat valid (registered).
- out_data  output  DATA_W  output beat data (registered).
- out_src  output  $clog2(NUM_CLIENTS)  index of the client that produced the beat.
- out_last  output  1  final beat of the burst.
- out_ready  input  1  downstream accept.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: clk rising edge; rst_n asynchronous, active-low.
- Reset values: state=IDLE; cli_ready, cli_done, out_valid, out_data, out_src, out_last and busy all 0; beat counter 0.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - When grant!=0, latch owner = index of the lowest set bit and cnt = cli_len[owner]; go to XFER next cycle.
  - Latency from grant to cli_ready is 1 cycle.
- XFER:
  - cli_ready[owner] = !out_valid || out_ready; all other cli_ready bits are 0.
  - Beat handshake = cli_valid[owner] && cli_ready[owner].
  - On a handshake: out_data<=cli_data[owner], out_src<=owner, out_valid<=1, out_last<=(cnt==0), and cnt decrements.
- Output stage:
  - out_valid clears when out_ready && out_valid and no new beat loads in the same cycle.
  - A load and a drain in the same cycle keep out_valid=1, which gives full throughput of 1 beat/cycle.
  - Held output values must not change while out_valid && !out_ready.
- Last beat (handshake with cnt==0): cli_done[owner] pulses high for exactly 1 cycle starting the next cycle, aligned with out_last becoming visible. State goes to RELEASE.
- RELEASE:
  - cli_ready=0.
  - Stay until grant[owner]==0, then go to IDLE.
  - A grant to a different client seen in the same cycle is taken on the next IDLE cycle, never in RELEASE.
- Grant deasserting or changing during XFER is ignored; the latched owner completes its burst.
- A single-beat burst (cli_len=0) goes IDLE -> XFER -> RELEASE with one handshake.
- Maximum burst length cli_len=2^LEN_W-1 transfers 2^LEN_W beats; the counter never wraps.
- RELEASE to IDLE is not blocked by a pending out_valid; the output register drains independently.
- Reset asserted mid-burst clears everything immediately. No partial-burst replay.

Optional Feature:
- Macro RR_XFER_CHECK_EN.
- When defined, adds output err (1 bit, reset 0, sticky until reset). err sets the cycle after either:
  - grant has more than one bit set while the block is in IDLE, or
  - grant[owner] falls during XFER.
- When defined, a simulation-only assertion fires on the same conditions.
- When undefined: no err port, no check logic; behaviour is otherwise identical.

Test Plan:
- grant=4'b0010, cli_len[1]=2, cli_valid[1] held high, out_ready=1 -> cli_ready[1] high from cycle+1. Three beats appear on consecutive cycles with out_src=1, out_last on the 3rd. cli_done[1] pulses once. busy stays high until grant[1] drops.
- Same burst with out_ready=0 for 3 cycles after the first beat -> out_data holds the first beat, cli_ready[1]=0 while stalled, no beat lost or duplicated; 3 beats total.
- cli_len[0]=0, grant=4'b0001 held for 2 cycles after cli_done -> exactly 1 beat, state held in RELEASE until grant=0, no second burst.
- Back-to-back: grant moves 0001->0100 the cycle grant[0] falls -> client 2 burst starts in the following IDLE cycle, and out_src switches 0->2 with no gap beyond 2 cycles.
- Reset asserted after 2 of 8 beats (cli_len=7) -> all outputs return to 0 asynchronously. After release the block is IDLE and re-accepts a grant.
- With RR_XFER_CHECK_EN: grant=4'b0011 in IDLE -> err=1 next cycle and stays 1; client 0 owns the burst.

Source files
------------

// File: rtl/rr_burst_xfer.sv
// rtl/rr_burst_xfer.sv - grant-driven burst mover with a registered valid/ready output stage
// Optional protocol checker (err output + assertion) enabled by defining RR_XFER_CHECK_EN.
module rr_burst_xfer #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CLIENTS-1:0]         grant,
    input  logic [NUM_CLIENTS*LEN_W-1:0]   cli_len,
    input  logic [NUM_CLIENTS*DATA_W-1:0]  cli_data,
    input  logic [NUM_CLIENTS-1:0]         cli_valid,
    output logic [NUM_CLIENTS-1:0]         cli_ready,
    output logic [NUM_CLIENTS-1:0]         cli_done,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(NUM_CLIENTS)-1:0] out_src,
    output logic                           out_last,
    input  logic                           out_ready,
`ifdef RR_XFER_CHECK_EN
    output logic                           err,
`endif
    output logic                           busy
);

    localparam int SRC_W = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    state_t                   state;
    logic [SRC_W-1:0]         owner;
    logic [SRC_W-1:0]         grant_idx;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         grant_len;
    logic [DATA_W-1:0]        own_data;
    logic [NUM_CLIENTS-1:0]   own_onehot;
    logic                     own_valid;
    logic                     own_grant;
    logic                     stage_free;
    logic                     beat_hs;

    // Lowest set grant bit wins, so a malformed multi-hot grant still picks one owner.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (grant[i]) grant_idx = SRC_W'(i);
        end
    end

    always_comb begin
        grant_len  = '0;
        own_data   = '0;
        own_valid  = 1'b0;
        own_grant  = 1'b0;
        own_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_idx == SRC_W'(i)) grant_len = cli_len[i*LEN_W +: LEN_W];
            if (owner == SRC_W'(i)) begin
                own_data      = cli_data[i*DATA_W +: DATA_W];
                own_valid     = cli_valid[i];
                own_grant     = grant[i];
                own_onehot[i] = 1'b1;
            end
        end
    end

    assign stage_free = !out_valid || out_ready;
    assign beat_hs    = (state == XFER) && stage_free && own_valid;
    assign cli_ready  = ((state == XFER) && stage_free) ? own_onehot : '0;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            cnt       <= '0;
            cli_done  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            cli_done <= '0;
            if (beat_hs) begin
                out_valid <= 1'b1;
                out_data  <= own_data;
                out_src   <= owner;
                out_last  <= (cnt == '0);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner <= grant_idx;
                        cnt   <= grant_len;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat_hs) begin
                        if (cnt == '0) begin
                            cli_done <= own_onehot;
                            state    <= RELEASE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // Wait for the arbiter to retire this grant so it cannot restart a burst.
                    if (!own_grant) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_XFER_CHECK_EN
    logic multi_grant;
    logic owner_drop;
    logic chk_hit;

    assign multi_grant = (state == IDLE) && (|(grant & (grant - NUM_CLIENTS'(1))));
    assign owner_drop  = (state == XFER) && !own_grant;
    assign chk_hit     = multi_grant || owner_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (chk_hit) err <= 1'b1;
    end

    chk_grant_protocol: assert property (@(posedge clk) disable iff (!rst_n) !chk_hit);
`endif

endmodule
